// File: rtl/gcd_controller.sv
// Control FSM for the 4-bit subtractive GCD datapath: it sequences the load, compare,
// subtract and latch strobes, and rejects zero operands and runaway iteration.
module gcd_controller #(
  parameter logic [3:0] MAX_ITER = 4'd15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       ack,
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       x_neq_y,
  input  logic       x_lt_y,
  output logic       x_sel,
  output logic       x_ld,
  output logic       y_sel,
  output logic       y_ld,
  output logic       d_ld,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] iter_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CMP, S_SUBX, S_SUBY, S_LATCH, S_DONE, S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] iter_q, iter_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      // NOTE: registers take non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    state_d = state_q;
    iter_d  = iter_q;
    x_sel   = 1'b0;
    x_ld    = 1'b0;
    y_sel   = 1'b0;
    y_ld    = 1'b0;
    d_ld    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_d  = '0;
          state_d = (x_i == 4'd0 || y_i == 4'd0) ? S_ERR : S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        x_ld    = 1'b1;
        y_ld    = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        busy = 1'b1;
        // Equality wins over the iteration limit, so a run finishing on its last allowed step succeeds.
        if (!x_neq_y)               state_d = S_LATCH;
        else if (iter_q == MAX_ITER) state_d = S_ERR;
        else if (x_lt_y)            state_d = S_SUBY;
        else                        state_d = S_SUBX;
      end
      S_SUBX: begin
        busy    = 1'b1;
        x_sel   = 1'b1;
        x_ld    = 1'b1;
        iter_d  = iter_q + 4'd1;
        state_d = S_CMP;
      end
      S_SUBY: begin
        busy    = 1'b1;
        y_sel   = 1'b1;
        y_ld    = 1'b1;
        iter_d  = iter_q + 4'd1;
        state_d = S_CMP;
      end
      S_LATCH: begin
        busy    = 1'b1;
        d_ld    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (ack) state_d = S_IDLE;
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign iter_o = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: two instances (MAX_ITER 15 and 3), each with a behavioural
// datapath, checked against a table of vectors, hand sequences and randomized runs.
module tb_gcd_controller;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, ack = 1'b0;
  logic [3:0] x_in = '0, y_in = '0;

  logic       xneq_a, xlt_a, xsel_a, xld_a, ysel_a, yld_a, dld_a, busy_a, done_a, err_a;
  logic       xneq_b, xlt_b, xsel_b, xld_b, ysel_b, yld_b, dld_b, busy_b, done_b, err_b;
  logic [3:0] iter_a, iter_b;
  logic [3:0] dx_a, dy_a, dd_a, dx_b, dy_b, dd_b;

  always #5 CLK = ~CLK;

  gcd_controller #(.MAX_ITER(4'd15)) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .ack(ack), .x_i(x_in), .y_i(y_in),
    .x_neq_y(xneq_a), .x_lt_y(xlt_a), .x_sel(xsel_a), .x_ld(xld_a), .y_sel(ysel_a),
    .y_ld(yld_a), .d_ld(dld_a), .busy(busy_a), .done(done_a), .err(err_a), .iter_o(iter_a)
  );

  gcd_controller #(.MAX_ITER(4'd3)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .ack(ack), .x_i(x_in), .y_i(y_in),
    .x_neq_y(xneq_b), .x_lt_y(xlt_b), .x_sel(xsel_b), .x_ld(xld_b), .y_sel(ysel_b),
    .y_ld(yld_b), .d_ld(dld_b), .busy(busy_b), .done(done_b), .err(err_b), .iter_o(iter_b)
  );

  // Behavioural subtractive datapaths, one per controller.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dx_a <= '0; dy_a <= '0; dd_a <= '0;
      dx_b <= '0; dy_b <= '0; dd_b <= '0;
    end else begin
      if (xld_a) dx_a <= xsel_a ? dx_a - dy_a : x_in;
      if (yld_a) dy_a <= ysel_a ? dy_a - dx_a : y_in;
      if (dld_a) dd_a <= dx_a;
      if (xld_b) dx_b <= xsel_b ? dx_b - dy_b : x_in;
      if (yld_b) dy_b <= ysel_b ? dy_b - dx_b : y_in;
      if (dld_b) dd_b <= dx_b;
    end
  end
  assign xneq_a = (dx_a != dy_a);
  assign xlt_a  = (dx_a <  dy_a);
  assign xneq_b = (dx_b != dy_b);
  assign xlt_b  = (dx_b <  dy_b);

  logic [11:0] out_a, out_b;
  assign out_a = {xsel_a, xld_a, ysel_a, yld_a, dld_a, busy_a, done_a, err_a, iter_a};
  assign out_b = {xsel_b, xld_b, ysel_b, yld_b, dld_b, busy_b, done_b, err_b, iter_b};

  logic       sel_b = 1'b0;
  logic       s_xsel, s_xld, s_ysel, s_yld, s_dld, s_busy, s_done, s_err;
  logic [3:0] s_iter, s_d;
  always_comb begin
    if (sel_b) begin
      {s_xsel, s_xld, s_ysel, s_yld, s_dld, s_busy, s_done, s_err, s_iter} = out_b;
      s_d = dd_b;
    end else begin
      {s_xsel, s_xld, s_ysel, s_yld, s_dld, s_busy, s_done, s_err, s_iter} = out_a;
      s_d = dd_a;
    end
  end

  int    n_pass = 0, n_checks = 0;
  int    edges_g;
  int    last_d[2];
  string seq;
  bit    saw_ld, saw_dld, saw_nobusy, saw_bad_sel;

  typedef struct {
    bit         use_b;
    logic [3:0] x;
    logic [3:0] y;
    bit         e_err;
    int         e_iter;
    int         e_d;
    int         e_lo;
    int         e_hi;
  } vec_t;

  vec_t  vecs[7];
  string seqs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic check_seq(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got strobes \"%s\", expected \"%s\"", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Record the strobe state seen after each edge as L/X/Y/D letters plus sanity flags.
  task automatic note();
    if (s_xld || s_yld) saw_ld = 1'b1;
    if (s_dld) saw_dld = 1'b1;
    if ((s_xsel && !s_xld) || (s_ysel && !s_yld)) saw_bad_sel = 1'b1;
    if (!s_busy && !s_done) saw_nobusy = 1'b1;
    if (s_xld && !s_xsel && s_yld && !s_ysel) seq = {seq, "L"};
    else if (s_xsel) seq = {seq, "X"};
    else if (s_ysel) seq = {seq, "Y"};
    else if (s_dld)  seq = {seq, "D"};
  endtask

  task automatic step();
    tick();
    edges_g++;
    note();
  endtask

  task automatic begin_run(input bit use_b, input logic [3:0] x, input logic [3:0] y);
    sel_b = use_b;
    x_in = x;
    y_in = y;
    seq = "";
    saw_ld = 1'b0; saw_dld = 1'b0; saw_nobusy = 1'b0; saw_bad_sel = 1'b0;
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    edges_g = 0;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done();
    while (!s_done && edges_g < 100) step();
  endtask

  task automatic ack_idle(input string name);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({name, " done after ack"}, s_done, 0);
    check({name, " busy after ack"}, s_busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input string exp_seq, input string name);
    begin_run(v.use_b, v.x, v.y);
    wait_done();
    check({name, " done"}, s_done, 1);
    check_range({name, " latency"}, edges_g, v.e_lo, v.e_hi);
    check({name, " err"}, s_err, v.e_err);
    check({name, " iter"}, s_iter, v.e_iter);
    check({name, " d_o"}, s_d, v.e_d);
    check({name, " d_ld seen"}, saw_dld, !v.e_err);
    check({name, " load seen"}, saw_ld, (v.x != 0 && v.y != 0));
    check({name, " busy gap"}, saw_nobusy, 0);
    check({name, " sel without ld"}, saw_bad_sel, 0);
    if (exp_seq != "*") check_seq({name, " strobes"}, seq, exp_seq);
    if (!v.e_err) last_d[v.use_b] = v.e_d;
    ack_idle(name);
  endtask

  function automatic void ref_gcd(input int a, input int b, output int g, output int n);
    n = 0;
    while (a != b) begin
      if (a > b) a = a - b;
      else b = b - a;
      n++;
    end
    g = a;
  endfunction

  initial begin
    string s15;
    bit    held;
    s15 = "L";
    for (int i = 0; i < 14; i++) s15 = {s15, "X"};
    s15 = {s15, "D"};

    vecs[0] = '{1'b0, 4'd12, 4'd8,  1'b0, 2,  4, 8,  8};  seqs[0] = "LXYD";
    vecs[1] = '{1'b0, 4'd5,  4'd5,  1'b0, 0,  5, 4,  4};  seqs[1] = "LD";
    vecs[2] = '{1'b0, 4'd15, 4'd1,  1'b0, 14, 1, 32, 32}; seqs[2] = s15;
    vecs[3] = '{1'b0, 4'd0,  4'd7,  1'b1, 0,  1, 1,  1};  seqs[3] = "";
    vecs[4] = '{1'b0, 4'd9,  4'd0,  1'b1, 0,  1, 1,  1};  seqs[4] = "";
    vecs[5] = '{1'b1, 4'd6,  4'd4,  1'b0, 2,  2, 8,  8};  seqs[5] = "LXYD";
    vecs[6] = '{1'b1, 4'd15, 4'd1,  1'b1, 3,  2, 9,  10}; seqs[6] = "LXXX";

    // Reset state
    tick();
    tick();
    check("reset outputs a", out_a, 0);
    check("reset outputs b", out_b, 0);
    RESET = 1'b0;
    tick();
    check("idle outputs a", out_a, 0);
    last_d[0] = 0;
    last_d[1] = 0;

    foreach (vecs[i]) run_vec(vecs[i], seqs[i], $sformatf("vec%0d", i));

    // Hold DONE without ack, then ack together with start
    begin_run(1'b0, 4'd12, 4'd8);
    wait_done();
    held = s_done;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!s_done) held = 1'b0;
    end
    check("done held 20 cycles", held, 1);
    ack = 1'b1;
    start_a = 1'b1;
    tick();
    ack = 1'b0;
    start_a = 1'b0;
    check("ack+start done", s_done, 0);
    check("ack+start busy", s_busy, 0);
    tick();
    tick();
    check("ack+start no new run", s_busy, 0);
    check("ack+start iter kept", s_iter, 2);

    // Start pulse while busy is ignored
    begin_run(1'b0, 4'd12, 4'd8);
    while (edges_g < 3) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_done();
    check("busy start latency", edges_g, 8);
    check("busy start d_o", s_d, 4);
    ack_idle("busy start");
    tick();
    tick();
    check("busy start not queued", s_busy, 0);

    // Asynchronous reset during SUBY of gcd(12,8)
    begin_run(1'b0, 4'd12, 4'd8);
    while (edges_g < 5) step();
    check("in SUBY before reset", {s_ysel, s_yld}, 2'b11);
    #2 RESET = 1'b1;
    #1;
    check("mid-run reset outputs", out_a, 0);
    #2 RESET = 1'b0;
    tick();
    check("after reset idle", out_a, 0);
    last_d[0] = 0;
    last_d[1] = 0;

    // Randomized runs against the arithmetic reference
    for (int i = 0; i < 14; i++) begin
      vec_t v;
      int   g, n, mx;
      v.use_b = 1'($urandom_range(0, 1));
      v.x = 4'($urandom_range(0, 15));
      v.y = 4'($urandom_range(0, 15));
      mx = v.use_b ? 3 : 15;
      if (v.x == 0 || v.y == 0) begin
        v.e_err = 1'b1; v.e_iter = 0; v.e_d = last_d[v.use_b]; v.e_lo = 1; v.e_hi = 1;
      end else begin
        ref_gcd(int'(v.x), int'(v.y), g, n);
        if (n <= mx) begin
          v.e_err = 1'b0; v.e_iter = n; v.e_d = g; v.e_lo = 4 + 2 * n; v.e_hi = 4 + 2 * n;
        end else begin
          v.e_err = 1'b1; v.e_iter = mx; v.e_d = last_d[v.use_b];
          v.e_lo = 3 + 2 * mx; v.e_hi = 4 + 2 * mx;
        end
      end
      run_vec(v, "*", $sformatf("rnd%0d(%0d,%0d,max%0d)", i, v.x, v.y, mx));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
